riscv_multicycle_ctrl: RTL

Multi-cycle sequencer for the RV32I datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared memory port with a ready handshake. It drives PC, IR, register-file and memory strobes from the IR opcode and the ALU compare result. It sits between the IR/ALU and the unified instruction/data memory, and replaces single-cycle control when memory has wait states.

---
 rtl/riscv_multicycle_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Strobes decode from the registered state; ir_write, SW pc_write and branch pc_src also see inputs.
module riscv_multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);
  localparam int unsigned WAIT_W = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [6:0]        op_q;
  logic [WAIT_W-1:0] wait_q;
  logic              legal;
  logic              in_access;
  logic              timeout;
  logic              done;

  assign state     = state_q;
  assign legal     = opcode inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI};
  assign in_access = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout   = in_access && !mem_ready && (wait_q == WAIT_W'(MAX_WAIT));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; done marks the instruction's completion cycle
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_HALT;
      end
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (op_q == OP_BR)                         done    = 1'b1;
        else if ((op_q == OP_LW) || (op_q == OP_SW)) state_d = S_MEM;
        else                                       state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_SW) done    = 1'b1;
          else               state_d = S_WB;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_WB:     done    = 1'b1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    if (done) state_d = run ? S_FETCH : S_IDLE;
  end

  // Strobe decode
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_EXEC: begin
        if (op_q == OP_BR) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_we   = (op_q == OP_SW);
        // PC advances only once, when the store actually completes
        pc_write = (op_q == OP_SW) && mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (op_q)
          OP_LW:   wb_sel = 2'b01;
          OP_JAL:  begin wb_sel = 2'b10; pc_src = 2'b01; end
          OP_JALR: begin wb_sel = 2'b10; pc_src = 2'b10; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Opcode latch, wait counter, sticky flags and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      wait_q  <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      retired <= '0;
    end else begin
      if (state_q == S_DECODE) op_q <= opcode;
      if (in_access && (state_d == state_q)) wait_q <= wait_q + WAIT_W'(1);
      else                                   wait_q <= '0;
      if ((state_q == S_DECODE) && !legal) illegal <= 1'b1;
      if (timeout) bus_err <= 1'b1;
      if (done)    retired <= retired + CNT_W'(1);
    end
  end

endmodule
